// File: rtl/tft_seq_cmd_if.sv
// Host command channel for tft_frame_sequencer: valid/ready handshake carrying
// an opcode and a colour code.
interface tft_seq_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_color;

  modport master (output cmd_valid, output cmd_op, output cmd_color, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_color, output cmd_ready);
endinterface

// File: rtl/tft_frame_sequencer.sv
// Frame-level colour sequencer for the TFT test path: steps a colour code per VD frame,
// applies host commands at frame boundaries. Optional watchdog: define TFT_SEQ_WDOG_EN.
module tft_frame_sequencer #(
  parameter int FRAMES_PER_COLOR = 100,
  parameter int FCNT_W           = 8,
  parameter int WDOG_CYCLES      = 600000
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               VD,
  tft_seq_cmd_if.slave       cmd,
  output logic [2:0]         color_code,
  output logic               frame_tick,
  output logic [15:0]        frame_total,
  output logic               hold_mode,
  output logic               sync_lost,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue
);

  typedef enum logic [0:0] {S_AUTO = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [1:0] OP_AUTO  = 2'd0;
  localparam logic [1:0] OP_HOLD  = 2'd1;
  localparam logic [1:0] OP_FORCE = 2'd2;
  localparam logic [1:0] OP_STEP  = 2'd3;

  localparam int                FPC_EFF  = (FRAMES_PER_COLOR < 1) ? 1 : FRAMES_PER_COLOR;
  localparam logic [FCNT_W-1:0] LAST_CNT = FCNT_W'(FPC_EFF - 1);

  function automatic logic [23:0] color_lut(input logic [2:0] code);
    logic [23:0] rgb;
    case (code)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFF0000;
      3'd2:    rgb = 24'h00FF00;
      3'd3:    rgb = 24'h0000FF;
      3'd4:    rgb = 24'h000000;
      3'd5:    rgb = 24'h00FFFF;
      3'd6:    rgb = 24'hFF00FF;
      3'd7:    rgb = 24'hFFFF00;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        color_q, color_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0]       total_q, total_d;
  logic              vd_d_q;
  logic              tick_q;
  logic              hold_q, hold_d;
  logic              ready_q, ready_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_op_q, pend_op_d;
  logic [2:0]        pend_color_q, pend_color_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              fb;
  logic              accept;

  assign fb     = vd_d_q & ~VD;
  assign accept = cmd.cmd_valid & ready_q;

  // A pending command takes the place of the auto step at its boundary; a command
  // accepted on the boundary cycle itself is only latched here, never applied.
  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    pend_op_d    = pend_op_q;
    pend_color_d = pend_color_q;
    total_d      = total_q;
    if (fb) begin
      total_d = total_q + 16'd1;
      if (pend_q) begin
        pend_d = 1'b0;
        case (pend_op_q)
          OP_AUTO: begin
            state_d = S_AUTO;
            fcnt_d  = '0;
          end
          OP_HOLD: begin
            state_d = S_HOLD;
          end
          OP_FORCE: begin
            color_d = pend_color_q;
            state_d = S_HOLD;
            fcnt_d  = '0;
          end
          OP_STEP: begin
            color_d = color_q + 3'd1;
            fcnt_d  = '0;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end else if (state_q == S_AUTO) begin
        if (fcnt_q == LAST_CNT) begin
          color_d = color_q + 3'd1;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end else begin
        fcnt_d = fcnt_q;
      end
    end else begin
      total_d = total_q;
    end
    if (accept) begin
      pend_d       = 1'b1;
      pend_op_d    = cmd.cmd_op;
      pend_color_d = cmd.cmd_color;
    end else begin
      pend_op_d = pend_op_d;
    end
    ready_d = ~pend_d;
    hold_d  = (state_d == S_HOLD);
  end

`ifdef TFT_SEQ_WDOG_EN
  localparam int             WD_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            lost_q, lost_d;

  // Saturating count of cycles since the last boundary; black screen while lost.
  always_comb begin
    wd_d   = wd_q;
    lost_d = lost_q;
    if (fb) begin
      wd_d   = '0;
      lost_d = 1'b0;
    end else begin
      if (wd_q != WD_MAX) begin
        wd_d = wd_q + WD_W'(1);
      end else begin
        wd_d = wd_q;
      end
      lost_d = (wd_d == WD_MAX);
    end
    rgb_d = lost_d ? 24'h000000 : color_lut(color_q);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wd_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      lost_q <= lost_d;
    end
  end

  assign sync_lost = lost_q;
`else
  assign rgb_d     = color_lut(color_q);
  assign sync_lost = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_AUTO;
      color_q      <= 3'd0;
      fcnt_q       <= '0;
      total_q      <= 16'd0;
      vd_d_q       <= 1'b0;
      tick_q       <= 1'b0;
      hold_q       <= 1'b0;
      ready_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_op_q    <= 2'd0;
      pend_color_q <= 3'd0;
      rgb_q        <= 24'hFFFFFF;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      fcnt_q       <= fcnt_d;
      total_q      <= total_d;
      vd_d_q       <= VD;
      tick_q       <= fb;
      hold_q       <= hold_d;
      ready_q      <= ready_d;
      pend_q       <= pend_d;
      pend_op_q    <= pend_op_d;
      pend_color_q <= pend_color_d;
      rgb_q        <= rgb_d;
    end
  end

  assign cmd.cmd_ready      = ready_q;
  assign color_code         = color_q;
  assign frame_tick         = tick_q;
  assign frame_total        = total_q;
  assign hold_mode          = hold_q;
  assign {Red, Green, Blue} = rgb_q;

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// Directed self-checking bench for tft_frame_sequencer (FRAMES_PER_COLOR=2).
module tb_tft_frame_sequencer;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        VD;
  logic [2:0]  color_code;
  logic        frame_tick;
  logic [15:0] frame_total;
  logic        hold_mode;
  logic        sync_lost;
  logic [7:0]  Red, Green, Blue;
  int          checks = 0;
  int          failures = 0;

  tft_seq_cmd_if bus ();

  tft_frame_sequencer #(.FRAMES_PER_COLOR(2), .FCNT_W(8), .WDOG_CYCLES(100)) dut (
    .CLK(CLK), .Reset(Reset), .VD(VD), .cmd(bus.slave),
    .color_code(color_code), .frame_tick(frame_tick), .frame_total(frame_total),
    .hold_mode(hold_mode), .sync_lost(sync_lost), .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // VD falls for one cycle; returns at the negedge after the boundary edge.
  task automatic frame();
    VD = 1'b0;
    @(negedge CLK);
    VD = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] col);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_color = col;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; VD = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_color = 3'd0;
    tick(3);
    checks++; if (color_code !== 3'd0) begin failures++; $display("FAIL rst_color got=%0d exp=0", color_code); end
    checks++; if (frame_total !== 16'd0) begin failures++; $display("FAIL rst_total got=%0d exp=0", frame_total); end
    checks++; if ({frame_tick, hold_mode, sync_lost, bus.cmd_ready} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {frame_tick, hold_mode, sync_lost, bus.cmd_ready}); end
    checks++; if ({Red, Green, Blue} !== 24'hFFFFFF) begin failures++; $display("FAIL rst_rgb got=%h exp=ffffff", {Red, Green, Blue}); end
    Reset = 1'b0;
    tick(1);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_auto();
    logic [2:0] exp_col [5] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    for (int f = 0; f < 5; f++) begin
      tick(3);
      frame();
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL auto_tick f=%0d got=%b exp=1", f, frame_tick); end
      checks++; if (color_code !== exp_col[f]) begin failures++; $display("FAIL auto_color f=%0d got=%0d exp=%0d", f, color_code, exp_col[f]); end
      tick(1);
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL auto_tick_low f=%0d got=%b exp=0", f, frame_tick); end
    end
    checks++; if (frame_total !== 16'd5) begin failures++; $display("FAIL auto_total got=%0d exp=5", frame_total); end
    checks++; if ({Red, Green, Blue} !== 24'h00FF00) begin failures++; $display("FAIL auto_rgb got=%h exp=00ff00", {Red, Green, Blue}); end
  endtask

  task automatic test_force();
    tick(2);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL force_ready_pre got=%b exp=1", bus.cmd_ready); end
    send(2'd2, 3'd6);
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL force_ready_low got=%b exp=0", bus.cmd_ready); end
    tick(4);
    checks++; if ({bus.cmd_ready, color_code} !== {1'b0, 3'd2}) begin failures++; $display("FAIL force_wait got=%b/%0d exp=0/2", bus.cmd_ready, color_code); end
    frame();
    checks++; if ({color_code, hold_mode, bus.cmd_ready} !== {3'd6, 1'b1, 1'b1}) begin failures++; $display("FAIL force_apply got=%0d/%b/%b exp=6/1/1", color_code, hold_mode, bus.cmd_ready); end
    tick(1);
    checks++; if ({Red, Green, Blue} !== 24'hFF00FF) begin failures++; $display("FAIL force_rgb got=%h exp=ff00ff", {Red, Green, Blue}); end
    for (int f = 0; f < 3; f++) begin tick(2); frame(); end
    checks++; if ({color_code, hold_mode} !== {3'd6, 1'b1}) begin failures++; $display("FAIL force_hold got=%0d/%b exp=6/1", color_code, hold_mode); end
    checks++; if (frame_total !== 16'd9) begin failures++; $display("FAIL force_total got=%0d exp=9", frame_total); end
  endtask

  task automatic test_step_wrap();
    send(2'd2, 3'd7); tick(1); frame();
    checks++; if (color_code !== 3'd7) begin failures++; $display("FAIL wrap_seven got=%0d exp=7", color_code); end
    send(2'd3, 3'd0); tick(1); frame();
    checks++; if ({color_code, hold_mode} !== {3'd0, 1'b1}) begin failures++; $display("FAIL wrap_step got=%0d/%b exp=0/1", color_code, hold_mode); end
    tick(1);
    checks++; if ({Red, Green, Blue} !== 24'hFFFFFF) begin failures++; $display("FAIL wrap_rgb got=%h exp=ffffff", {Red, Green, Blue}); end
  endtask

  task automatic test_back_to_back();
    tick(2);
    VD = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3;
    @(negedge CLK);
    VD = 1'b1; bus.cmd_valid = 1'b0;
    checks++; if ({frame_tick, color_code, bus.cmd_ready} !== {1'b1, 3'd0, 1'b0}) begin failures++; $display("FAIL fbcmd_same got=%b/%0d/%b exp=1/0/0", frame_tick, color_code, bus.cmd_ready); end
    tick(3); frame();
    checks++; if ({color_code, bus.cmd_ready} !== {3'd1, 1'b1}) begin failures++; $display("FAIL fbcmd_next got=%0d/%b exp=1/1", color_code, bus.cmd_ready); end
    send(2'd0, 3'd0); tick(1); frame();
    checks++; if ({color_code, hold_mode} !== {3'd1, 1'b0}) begin failures++; $display("FAIL auto_cmd got=%0d/%b exp=1/0", color_code, hold_mode); end
    tick(2); frame(); tick(2); frame();
    checks++; if (color_code !== 3'd2) begin failures++; $display("FAIL auto_resume got=%0d exp=2", color_code); end
    checks++; if (frame_total !== 16'd16) begin failures++; $display("FAIL b2b_total got=%0d exp=16", frame_total); end
  endtask

  task automatic test_reset_pending();
    send(2'd3, 3'd0);
    tick(1);
    Reset = 1'b1;
    tick(2);
    checks++; if ({color_code, bus.cmd_ready, frame_total} !== {3'd0, 1'b0, 16'd0}) begin failures++; $display("FAIL rstp_state got=%0d/%b/%0d exp=0/0/0", color_code, bus.cmd_ready, frame_total); end
    checks++; if ({Red, Green, Blue} !== 24'hFFFFFF) begin failures++; $display("FAIL rstp_rgb got=%h exp=ffffff", {Red, Green, Blue}); end
    Reset = 1'b0;
    tick(3); frame();
    checks++; if ({color_code, hold_mode, frame_total} !== {3'd0, 1'b0, 16'd1}) begin failures++; $display("FAIL rstp_nostep got=%0d/%b/%0d exp=0/0/1", color_code, hold_mode, frame_total); end
    tick(2); frame();
    checks++; if (color_code !== 3'd1) begin failures++; $display("FAIL rstp_auto got=%0d exp=1", color_code); end
  endtask

  task automatic test_wdog();
    tick(90);
    checks++; if (sync_lost !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", sync_lost); end
    tick(60);
`ifdef TFT_SEQ_WDOG_EN
    checks++; if ({sync_lost, Red, Green, Blue} !== {1'b1, 24'h000000}) begin failures++; $display("FAIL wdog_lost got=%b/%h exp=1/000000", sync_lost, {Red, Green, Blue}); end
    frame();
    checks++; if ({sync_lost, Red, Green, Blue} !== {1'b0, 24'hFF0000}) begin failures++; $display("FAIL wdog_clear got=%b/%h exp=0/ff0000", sync_lost, {Red, Green, Blue}); end
`else
    checks++; if ({sync_lost, Red, Green, Blue} !== {1'b0, 24'hFF0000}) begin failures++; $display("FAIL wdog_off got=%b/%h exp=0/ff0000", sync_lost, {Red, Green, Blue}); end
`endif
  endtask

  initial begin
    test_reset();
    test_auto();
    test_force();
    test_step_wrap();
    test_back_to_back();
    test_reset_pending();
    test_wdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
